hazard_unit_ext: RTL and testbench
==================================

# hazard_unit_ext

Parametrised hazard-detection unit for the five-stage MIPS pipeline, generalising the original load-use stall logic. Detects load-use hazards with a configurable memory latency, stalls branches resolved in ID when their operands are still in flight, and flushes IF/ID on taken branches and jumps. It also keeps saturating stall and flush counters for performance debug. Sits between the ID stage, the ID/EX and EX/MEM pipeline registers, and the PC/IF-ID hold logic.

## Interface
- REG_AW, 5, register-address width
- LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..4)
- CNT_W, 16, width of the performance counters
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  REG_AW  source registers of the instruction in IF/ID
- id_uses_rs, id_uses_rt  in  1  the instruction in ID actually reads that source
- id_is_branch  in  1  beq/bne in ID
- id_is_jump  in  1  j/jal/jr in ID
- id_branch_taken  in  1  ID comparator result; valid only when id_is_branch
- ex_rd  in  REG_AW  destination of the instruction in ID/EX
- ex_reg_write, ex_mem_read  in  1  ID/EX control bits
- mem_rd  in  REG_AW  destination of the instruction in EX/MEM
- mem_reg_write, mem_mem_read  in  1  EX/MEM control bits
- hold_pc  out  1  freeze the PC
- hold_if_id  out  1  freeze IF/ID
- bubble_id_ex  out  1  zero the ID/EX control fields
- flush_if_id  out  1  clear IF/ID to a nop
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total flushes, saturating

## Operation
- **Source matching.** match(r) = (r != 0) && ((r == id_rs && id_uses_rs) || (r == id_rt && id_uses_rt)). Register 0 never creates a hazard.
- **Load-use hazard.** ex_mem_read && match(ex_rd).
- **Branch hazard.** id_is_branch, plus either:
  - ex_reg_write && match(ex_rd), or
  - mem_mem_read && match(mem_rd).
- **hazard** = load-use hazard OR branch hazard. When asserted, hold_pc = hold_if_id = bubble_id_ex = 1.
- **FSM states: IDLE, LOAD_WAIT.**
  - IDLE → LOAD_WAIT on a load-use hazard when LOAD_STALL > 1. On entry, remain = LOAD_STALL − 1.
  - In LOAD_WAIT, all three stall outputs are forced to 1 regardless of the inputs. remain decrements each cycle.
  - LOAD_WAIT → IDLE when remain == 1 at a clock edge.
  - remain is ceil(log2(LOAD_STALL+1)) bits wide.
- **Flush.** flush_if_id = (id_is_jump || (id_is_branch && id_branch_taken)) && !hazard && state == IDLE.
  - Stall has priority: a branch that is stalled never flushes until its operands are ready.
- **Counters.**
  - stall_cnt increments on every cycle with hold_pc = 1.
  - flush_cnt increments on every cycle with flush_if_id = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- The stall and flush outputs are combinational from the current inputs and the current state, so they take effect in the same cycle the hazard is visible.
- State, remain and both counters update on the rising edge of clk.
- Load-use hazard costs exactly LOAD_STALL cycles of hold_pc:
  - the detection cycle, plus
  - LOAD_STALL − 1 cycles in LOAD_WAIT.
- The branch-after-ALU case costs 1 stall cycle. Branch-after-load costs 2: the load-use stall, then the MEM-stage branch stall.
- Flush is a single-cycle pulse. It is never asserted in the same cycle as hold_pc.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, remain = 0, both counters = 0.
  - All outputs are 0 while rst_n = 0. Registered values clear immediately; the combinational outputs are gated by !rst_n.
- Reset asserted mid-LOAD_WAIT abandons the stall. The first cycle after release evaluates from IDLE.
- Simultaneous hazard and jump: the stall wins, and the jump flushes on the first non-stalled cycle.

## Structure
- Shared package mips_pkg:
  - REG_AW default
  - hazard_state_t enum {IDLE, LOAD_WAIT}
  - zero-register constant REG_ZERO
- One sub-module: sat_counter (parameter W, inputs clk, rst_n, inc; output count), instantiated twice for the stall and flush counters.
- The remaining logic (match functions, FSM, output decode) lives in hazard_unit_ext.

## Test plan
- **Load-use, LOAD_STALL=1.** ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 → hold_pc = hold_if_id = bubble_id_ex = 1 for exactly 1 cycle; stall_cnt 0→1.
- **Load-use, LOAD_STALL=3.** Same stimulus for 1 cycle, then ex_mem_read=0 → hold_pc = 1 for 3 consecutive cycles, state returns to IDLE; stall_cnt = 3.
- **Register 0 and unused sources.** ex_mem_read=1, ex_rd=0, id_rs=0 → no stall. Also ex_rd=9, id_rt=9, id_uses_rt=0 → no stall.
- **Branch after ALU.** id_is_branch=1, id_branch_taken=1, ex_reg_write=1, ex_rd=4, id_rs=4 → 1 stall cycle with flush_if_id=0. Next cycle, no EX match → flush_if_id=1 for 1 cycle; flush_cnt=1.
- **Jump, then reset mid-stall.**
  - id_is_jump=1, no hazard → flush_if_id=1.
  - Then, with LOAD_STALL=3, trigger a load-use and drop rst_n in LOAD_WAIT → all outputs 0 immediately, both counters 0. After release with no hazard, hold_pc=0.
- **Saturation.** CNT_W=4, hold a stall condition for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline constants and the hazard FSM state type.
package mips_pkg;
    localparam int REG_AW_DEFAULT = 5;
    localparam logic [REG_AW_DEFAULT-1:0] REG_ZERO = '0;
    typedef enum logic {IDLE, LOAD_WAIT} hazard_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_d, count_q;

    always_comb count_d = (inc && count_q != '1) ? count_q + W'(1) : count_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/hazard_unit_ext.sv
// hazard_unit_ext: load-use / branch-operand stall detection with multi-cycle load
// wait, IF/ID flush on taken control transfers, and saturating stall/flush counters.
module hazard_unit_ext
    import mips_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic              id_is_jump,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    output logic              hold_pc,
    output logic              hold_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int RW = $clog2(LOAD_STALL + 1);

    hazard_state_t state_d, state_q;
    logic [RW-1:0] remain_d, remain_q;
    logic load_use, br_haz, hazard, in_wait, stall, flush;
    logic unused_ok;

    // Only the EX/MEM load bit matters for a branch; ALU results there are forwarded.
    assign unused_ok = mem_reg_write;

    function automatic logic match(input logic [REG_AW-1:0] r);
        return (r != REG_AW'(REG_ZERO)) &&
               ((r == id_rs && id_uses_rs) || (r == id_rt && id_uses_rt));
    endfunction

    always_comb begin
        load_use = ex_mem_read && match(ex_rd);
        br_haz   = id_is_branch && ((ex_reg_write && match(ex_rd)) || (mem_mem_read && match(mem_rd)));
        hazard   = load_use || br_haz;
        in_wait  = state_q == LOAD_WAIT;
        stall    = rst_n && (hazard || in_wait);
        flush    = rst_n && (id_is_jump || (id_is_branch && id_branch_taken)) && !hazard && !in_wait;
        state_d  = in_wait ? (remain_q == RW'(1) ? IDLE : LOAD_WAIT)
                           : ((load_use && LOAD_STALL > 1) ? LOAD_WAIT : IDLE);
        remain_d = in_wait ? remain_q - RW'(1)
                           : ((load_use && LOAD_STALL > 1) ? RW'(LOAD_STALL - 1) : remain_q);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end

    assign hold_pc      = stall;
    assign hold_if_id   = stall;
    assign bubble_id_ex = stall;
    assign flush_if_id  = flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush), .count(flush_cnt));
endmodule

// File: tb/tb_hazard_unit_ext.sv
// tb_hazard_unit_ext: table-driven and sequence checks of hazard_unit_ext with
// LOAD_STALL=1, LOAD_STALL=3 and a 4-bit counter instance sharing one stimulus.
module tb_hazard_unit_ext;
    logic clk = 0, rst_n = 0;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, id_branch_taken;
    logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;

    logic a_hp, a_hi, a_bb, a_fl, b_hp, b_hi, b_bb, b_fl, s_hp, s_hi, s_bb, s_fl;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
    logic [3:0]  s_sc, s_fc;

    int n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    hazard_unit_ext #(.LOAD_STALL(1)) d1 (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
        .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .hold_pc(a_hp),
        .hold_if_id(a_hi), .bubble_id_ex(a_bb), .flush_if_id(a_fl), .stall_cnt(a_sc), .flush_cnt(a_fc));

    hazard_unit_ext #(.LOAD_STALL(3)) d3 (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
        .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .hold_pc(b_hp),
        .hold_if_id(b_hi), .bubble_id_ex(b_bb), .flush_if_id(b_fl), .stall_cnt(b_sc), .flush_cnt(b_fc));

    hazard_unit_ext #(.LOAD_STALL(1), .CNT_W(4)) ds (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
        .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .hold_pc(s_hp),
        .hold_if_id(s_hi), .bubble_id_ex(s_bb), .flush_if_id(s_fl), .stall_cnt(s_sc), .flush_cnt(s_fc));

    typedef struct {
        logic [4:0] rs, rt;
        logic urs, urt, br, jmp, tk;
        logic [4:0] exrd;
        logic exw, exmr;
        logic [4:0] memrd;
        logic memmr;
        logic eh, ef;
    } vec_t;

    typedef struct { string nm; logic h, f; } exp_t;
    exp_t sb[$];

    function automatic vec_t mkv(input int rs, rt, urs, urt, br, jmp, tk, exrd, exw, exmr, memrd, memmr, eh, ef);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs[0]; v.urt = urt[0]; v.br = br[0]; v.jmp = jmp[0]; v.tk = tk[0];
        v.exrd = 5'(exrd); v.exw = exw[0]; v.exmr = exmr[0]; v.memrd = 5'(memrd); v.memmr = memmr[0];
        v.eh = eh[0]; v.ef = ef[0];
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt; id_is_branch = v.br;
        id_is_jump = v.jmp; id_branch_taken = v.tk; ex_rd = v.exrd; ex_reg_write = v.exw;
        ex_mem_read = v.exmr; mem_rd = v.memrd; mem_reg_write = 1'b0; mem_mem_read = v.memmr;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic push(input string nm, input logic h, input logic f);
        exp_t e;
        e.nm = nm; e.h = h; e.f = f;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic hp, input logic hi, input logic bb, input logic fl);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check({e.nm, ".hold_pc"}, int'(hp), int'(e.h));
        check({e.nm, ".hold_if_id"}, int'(hi), int'(e.h));
        check({e.nm, ".bubble_id_ex"}, int'(bb), int'(e.h));
        check({e.nm, ".flush_if_id"}, int'(fl), int'(e.f));
    endtask

    task automatic step_a(input string nm, input vec_t v);
        @(posedge clk); #1;
        apply(v);
        push(nm, v.eh, v.ef);
        @(negedge clk);
        pop_cmp(a_hp, a_hi, a_bb, a_fl);
    endtask

    task automatic step_b(input string nm, input vec_t v);
        @(posedge clk); #1;
        apply(v);
        push(nm, v.eh, v.ef);
        @(negedge clk);
        pop_cmp(b_hp, b_hi, b_bb, b_fl);
    endtask

    task automatic do_reset();
        apply(mkv(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    vec_t tbl[13];
    vec_t z, lu, v;
    int sh, sf;

    initial begin
        z  = mkv(0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0);
        lu = mkv(8,0,1,0,0,0,0, 8,0,1, 0,0, 1,0);
        tbl[0]  = lu;
        tbl[1]  = mkv(0,0,1,0,0,0,0, 0,0,1, 0,0, 0,0);
        tbl[2]  = mkv(0,9,0,0,0,0,0, 9,0,1, 0,0, 0,0);
        tbl[3]  = mkv(0,9,0,1,0,0,0, 9,0,1, 0,0, 1,0);
        tbl[4]  = mkv(4,0,1,0,1,0,1, 4,1,0, 0,0, 1,0);
        tbl[5]  = mkv(4,0,1,0,1,0,1, 5,1,0, 0,0, 0,1);
        tbl[6]  = mkv(4,0,1,0,1,0,0, 5,1,0, 0,0, 0,0);
        tbl[7]  = mkv(0,6,0,1,1,0,1, 0,0,0, 6,1, 1,0);
        tbl[8]  = mkv(4,0,1,0,0,0,0, 4,1,0, 0,0, 0,0);
        tbl[9]  = mkv(0,6,0,1,0,0,0, 0,0,0, 6,1, 0,0);
        tbl[10] = mkv(0,0,0,0,0,1,0, 0,0,0, 0,0, 0,1);
        tbl[11] = mkv(8,0,1,0,0,1,0, 8,0,1, 0,0, 1,0);
        tbl[12] = mkv(0,0,1,1,1,0,1, 0,1,0, 0,1, 0,1);
        apply(z);
        @(negedge clk);
        check("reset.hold_pc", int'(a_hp), 0);
        check("reset.flush", int'(a_fl), 0);
        check("reset.stall_cnt", int'(a_sc), 0);
        check("reset.flush_cnt", int'(a_fc), 0);
        rst_n = 1'b1;

        sh = 0; sf = 0;
        for (int i = 0; i < 13; i++) begin
            step_a($sformatf("vec%0d", i), tbl[i]);
            sh += int'(tbl[i].eh);
            sf += int'(tbl[i].ef);
        end
        step_a("vec_idle", z);
        check("table.stall_cnt", int'(a_sc), sh);
        check("table.flush_cnt", int'(a_fc), sf);

        // LOAD_STALL=1: one stall cycle only
        do_reset();
        step_a("ls1.detect", lu);
        step_a("ls1.after", z);
        check("ls1.stall_cnt", int'(a_sc), 1);

        // LOAD_STALL=3: three stall cycles; a jump during the wait must not flush
        do_reset();
        step_b("ls3.c0", lu);
        v = z; v.eh = 1'b1;
        step_b("ls3.c1", v);
        v = mkv(0,0,0,0,0,1,0, 0,0,0, 0,0, 1,0);
        step_b("ls3.c2_jump_in_wait", v);
        v.eh = 1'b0; v.ef = 1'b1;
        step_b("ls3.c3_jump_flush", v);
        step_b("ls3.c4", z);
        check("ls3.stall_cnt", int'(b_sc), 3);
        check("ls3.flush_cnt", int'(b_fc), 1);

        // Branch after ALU: one stall, then a single flush
        do_reset();
        step_a("br_alu.stall", tbl[4]);
        step_a("br_alu.flush", tbl[5]);
        step_a("br_alu.idle", z);
        check("br_alu.stall_cnt", int'(a_sc), 1);
        check("br_alu.flush_cnt", int'(a_fc), 1);

        // Reset asserted in LOAD_WAIT
        do_reset();
        step_b("rst.c0", lu);
        v = z; v.eh = 1'b1;
        step_b("rst.c1_wait", v);
        #2;
        rst_n = 1'b0;
        apply(tbl[11]);
        #1;
        check("rst.hold_pc", int'(b_hp), 0);
        check("rst.hold_if_id", int'(b_hi), 0);
        check("rst.bubble", int'(b_bb), 0);
        check("rst.flush", int'(b_fl), 0);
        check("rst.stall_cnt", int'(b_sc), 0);
        check("rst.flush_cnt", int'(b_fc), 0);
        @(negedge clk);
        apply(z);
        rst_n = 1'b1;
        step_b("rst.after_release", z);

        // Saturation of the 4-bit counter
        do_reset();
        @(posedge clk); #1;
        apply(lu);
        repeat (20) @(posedge clk);
        #1;
        apply(z);
        @(negedge clk);
        check("sat.stall_cnt_w4", int'(s_sc), 15);
        check("sat.stall_cnt_w16", int'(a_sc), 20);
        check("sat.flush_cnt_w4", int'(s_fc), 0);
        check("sat.hold_after", int'(s_hp), 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
